// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the FIFO family.
// Pure compile-time content, no logic.
package fifo_pkg;

    localparam int FIFO_DEF_W     = 8;
    localparam int FIFO_DEF_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master drives requests, slave is the FIFO.
// Status outputs are all registered inside the FIFO.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DEF_W,
    parameter int DEPTH  = FIFO_DEF_DEPTH
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// rst clears only the read register; the array itself is never cleared.
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DEF_W,
    parameter int DEPTH  = FIFO_DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Same-address read and write returns the old word (needed for read+write while full).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy, registered flags and error pulses around fifo_ram_dp.
// Read data 1 cycle after an accepted read; write while full only accepted alongside a read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DEF_W,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             rd_valid_q, overflow_q, underflow_q;
    logic             clr;
    logic             rd_ok, wr_ok;

    assign clr   = rst | bus.flush;
    assign rd_ok = bus.rd_en && !empty_q;
    assign wr_ok = bus.wr_en && (!full_q || bus.rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Flags follow next-state count so they line up with count_q every cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(DEPTH));
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= CNT_W'(AF_LEVEL));
            aempty_q    <= (count_d <= CNT_W'(AE_LEVEL));
            rd_valid_q  <= rd_ok;
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && !rd_ok;
        end
    end

    fifo_ram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (clr),
        .we    (wr_ok && !clr),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .re    (rd_ok && !clr),
        .raddr (rd_ptr_q),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO, the next generation of the team's 8x8 FIFO buffer.
- Configurable data width and power-of-two depth.
- Full simultaneous read/write support, occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and overflow/underflow error pulses.
- Sits between producer and consumer blocks as the standard buffering primitive; storage is a separate dual-port RAM sub-module.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- PTR_W, $clog2(DEPTH), derived read/write pointer width.
- CNT_W, $clog2(DEPTH+1), derived occupancy count width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents; same effect as rst on pointers, count and flags.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data, sampled when a write is accepted.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  read data, registered.
- rd_valid  output  1  rd_data holds the word of the read accepted in the previous cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  CNT_W  current occupancy.
- overflow  output  1  one-cycle pulse: write requested but rejected.
- underflow  output  1  one-cycle pulse: read requested but rejected.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). No asynchronous paths.
- Reset values (rst or flush): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (when AF_LEVEL>0), rd_valid=0, rd_data=0, overflow=0, underflow=0. RAM contents are not cleared.
- Priority: rst > flush > normal operation. rst or flush in any cycle discards all requests in that cycle; no error pulses are raised.
- Accept rules, evaluated on current-cycle flags:
  - rd_ok = rd_en && !empty.
  - wr_ok = wr_en && (!full || rd_en). A write while full is accepted only alongside a read.
- Write: on wr_ok, RAM[wr_ptr] <= wr_data and wr_ptr <= wr_ptr+1. The pointer wraps modulo DEPTH.
- Read latency is 1 cycle. On rd_ok, rd_data <= RAM[rd_ptr], rd_ptr <= rd_ptr+1 (wraps), and rd_valid <= 1 next cycle. Otherwise rd_valid <= 0 and rd_data holds its last value.
- Count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both or neither: unchanged.
- Flags are registered and derived from next-state count, so they are valid in the same cycle as count.
- Simultaneous read and write:
  - Empty: write accepted, read rejected (underflow=1), count becomes 1. No write-to-read bypass; the word is readable from the next cycle.
  - Full: both accepted, count stays DEPTH, full stays 1, no overflow.
  - Otherwise: both accepted, count unchanged.
- overflow <= wr_en && !wr_ok; underflow <= rd_en && !rd_ok. Each pulses for one cycle, in the cycle after the request.
- Rejected operations never modify pointers, count or RAM.
- Threshold ordering: with AE_LEVEL >= AF_LEVEL both almost flags may be 1 at once. This is legal and not checked.

Decomposition:
- Package fifo_pkg holds:
  - the clog2-based width helper functions;
  - default constants FIFO_DEF_W=8 and FIFO_DEF_DEPTH=8.
- Sub-module fifo_ram_dp:
  - simple dual-port RAM with parameters DATA_W and DEPTH;
  - write port (we, waddr, wdata) and registered read port (re, raddr, rdata), one-cycle latency;
  - one clock.
- sync_fifo_param holds the pointers, count, flags and error logic, and instantiates one fifo_ram_dp.

Test Plan (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset then idle: assert rst for 2 cycles -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, rd_data=0.
- Fill and drain: write 0x01..0x08, then one more write of 0x09 -> full=1, count=8, one overflow pulse. Then 8 reads -> rd_data 0x01..0x08 in order, each 1 cycle after its rd_en; empty=1 after the last read.
- Flag thresholds: write 6 words -> almost_full rises in the cycle count reaches 6; almost_empty falls when count reaches 3.
- Simultaneous on full: at count=8 assert wr_en=1 (0xAA) and rd_en=1 -> count stays 8, no overflow, rd_data=oldest word. 0xAA is read out in eighth position.
- Simultaneous on empty: at count=0 assert wr_en (0x55) and rd_en -> underflow=1, count=1, rd_valid=0. Next-cycle read returns 0x55.
- Wrap and flush: run 20 mixed random cycles against a reference queue, checking all data and count. Then flush mid-stream with wr_en=1 -> count=0, empty=1, no overflow, and the write in the flush cycle is discarded.
